// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Watches N input lines for events, records them as per-channel pending flags,
// and presents them one at a time on a valid/ready output. The output is
// granted round-robin, starting after the last channel granted. If a channel
// already has an event pending, a new event on it is dropped. A dropped event
// sets that channel's sticky overflow flag and increments a shared 8-bit
// saturating drop counter.
//
// Build option:
//   EDGE_EVENT_PULSE_MODE_EN  - when defined, an event is an isolated one-cycle
//                               high pulse (a 0,1,0 pattern over three samples)
//                               instead of a rising edge. This adds one cycle
//                               of latency.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   en         in   detection enable (pending/arbitration keep running when 0)
//   a          in   [N-1:0] monitored lines, synchronous to clk
//   out_ready  in   consumer accepts the presented event
//   ovf_clr    in   one-cycle pulse clearing ovf and drop_cnt
//   out_valid  out  an event is presented on out_id
//   out_id     out  [$clog2(N)-1:0] channel index of the presented event
//   pending    out  [N-1:0] recorded-but-not-issued event flags
//   ovf        out  [N-1:0] sticky per-channel overflow flags
//   drop_cnt   out  [7:0] saturating count of dropped events
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         a,
    input  logic                 out_ready,
    input  logic                 ovf_clr,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_id,
    output logic [N-1:0]         pending,
    output logic [N-1:0]         ovf,
    output logic [7:0]           drop_cnt
);

    localparam int IdW = $clog2(N);

    // Registered state
    logic [N-1:0]   a_r_q;
`ifdef EDGE_EVENT_PULSE_MODE_EN
    logic [N-1:0]   a_r2_q;
`endif
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   ovf_q,     ovf_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;
    logic           out_valid_q, out_valid_d;
    logic [IdW-1:0] out_id_q,  out_id_d;
    logic [IdW-1:0] last_q,    last_d;

    // Combinational intermediates
    logic [N-1:0]   evt;
    logic           load;
    logic           found;
    logic [IdW-1:0] sel;
    logic [N-1:0]   grant_clr;
    logic [N-1:0]   drop;
    logic [3:0]     n_drop;
    logic [7:0]     drop_base;
    logic [8:0]     drop_sum;

    // Event detection. en gates only the event itself. The delay registers
    // always follow a, so re-enabling while a line is high raises nothing.
`ifdef EDGE_EVENT_PULSE_MODE_EN
    assign evt = {N{en}} & ~a_r2_q & a_r_q & ~a;
`else
    assign evt = {N{en}} & a & ~a_r_q;
`endif

    // A new grant may be loaded when the output slot is empty, or when it is
    // being consumed in this same cycle.
    assign load = ~out_valid_q | out_ready;

    // Round-robin search over registered pending flags, starting one past the
    // last granted channel and wrapping at N-1.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
        found = 1'b0;
        sel   = last_q;
        for (int k = 1; k <= N; k++) begin
            if (!found && pending_q[(int'(last_q) + k) % N]) begin
                found = 1'b1;
                sel   = IdW'((int'(last_q) + k) % N);
            end
        end
    end

    // Pending, overflow and drop accounting. The grant clears its flag before
    // the new event is OR-ed in, so an event that arrives on the channel being
    // granted is kept (set wins) and is not counted as a drop.
    always_comb begin
        grant_clr = '0;
        if (load && found) begin
            grant_clr[sel] = 1'b1;
        end

        drop      = evt & pending_q & ~grant_clr;
        pending_d = (pending_q & ~grant_clr) | evt;

        // A clear and a drop in the same cycle: the drop is applied after the
        // clear, so that cycle's drops stay visible.
        ovf_d     = (ovf_clr ? '0 : ovf_q) | drop;

        n_drop = '0;
        for (int i = 0; i < N; i++) begin
            n_drop = n_drop + 4'(drop[i]);
        end
        drop_base  = ovf_clr ? 8'd0 : drop_cnt_q;
        drop_sum   = {1'b0, drop_base} + 9'(n_drop);
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Output slot: it holds while stalled. When it loads with nothing
    // pending, it empties and keeps the old id.
    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        last_d      = last_q;
        if (load) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_id_d    = sel;
                last_d      = sel;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Reset starts the pointer at N-1 so that channel 0 is searched first.
    // Reset drops the presented event and all pending events at once.
    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r_q       <= '0;
`ifdef EDGE_EVENT_PULSE_MODE_EN
            a_r2_q      <= '0;
`endif
            pending_q   <= '0;
            ovf_q       <= '0;
            drop_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            last_q      <= IdW'(N - 1);
        end else begin
            a_r_q       <= a;
`ifdef EDGE_EVENT_PULSE_MODE_EN
            a_r2_q      <= a_r_q;
`endif
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_edge_event_arbiter
//
// Self-checking bench for edge_event_arbiter with N = 4.
// - A table of directed vectors covers reset, grant order, stalls, drops,
//   clears, and the case where an event arrives as its channel is granted.
// - Hand-written sequences cover asynchronous reset during a handshake, a line
//   already high at reset release, drop-counter saturation, and the enable.
// - A long random run is compared cycle by cycle against a behavioural model.
// With EDGE_EVENT_PULSE_MODE_EN defined, a pulse-detection sequence replaces
// the edge-specific directed parts.
// -----------------------------------------------------------------------------
module tb_edge_event_arbiter;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   a;
    logic           out_ready;
    logic           ovf_clr;
    logic           out_valid;
    logic [IDW-1:0] out_id;
    logic [N-1:0]   pending;
    logic [N-1:0]   ovf;
    logic [7:0]     drop_cnt;

    edge_event_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a         (a),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_id    (out_id),
        .pending   (pending),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The model keeps the sample history of a and tracks the consumer slot
    // as plain variables.
    bit [N-1:0] m_h1, m_h2;
    bit [N-1:0] m_pend, m_ovf;
    bit         m_valid;
    int         m_id, m_last, m_drop;
    bit         use_model = 1'b0;

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_pend = '0; m_ovf = '0;
        m_valid = 1'b0; m_id = 0; m_last = N - 1; m_drop = 0;
    endtask

    task automatic model_step();
        bit ev [N];
        int g = -1;
        int drops = 0;
        bit take = !m_valid || out_ready;
        for (int i = 0; i < N; i++) begin
`ifdef EDGE_EVENT_PULSE_MODE_EN
            ev[i] = en && !m_h2[i] && m_h1[i] && !a[i];
`else
            ev[i] = en && a[i] && !m_h1[i];
`endif
        end
        if (take) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
            end
        end
        if (g >= 0) m_pend[g] = 1'b0;
        if (ovf_clr) begin
            m_ovf  = '0;
            m_drop = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
                if (m_pend[i]) begin
                    drops++;
                    m_ovf[i] = 1'b1;
                end else begin
                    m_pend[i] = 1'b1;
                end
            end
        end
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
        if (take) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_id    = g;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_h2 = m_h1;
        m_h1 = a;
    endtask

    // One clock. The model advances on the same edge the DUT samples, and the
    // outputs are read 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (use_model) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        a = '0; en = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0] a;
        logic         rdy;
        logic         clr;
        logic         e_valid;
        int           e_id;
        logic [N-1:0] e_pend;
        logic [N-1:0] e_ovf;
        int           e_drop;
    } vec_t;

    function automatic vec_t mk(logic [N-1:0] a_v, logic r, logic c, logic v, int id,
                                logic [N-1:0] p, logic [N-1:0] o, int d);
        vec_t t;
        t.a = a_v; t.rdy = r; t.clr = c; t.e_valid = v; t.e_id = id;
        t.e_pend = p; t.e_ovf = o; t.e_drop = d;
        return t;
    endfunction

    vec_t tbl [24];

    initial begin
        rst = 1'b0;
        a = '0; en = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        #12;
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_id",    32'(out_id),    32'(0));
        check("rst_pend",  32'(pending),   32'(0));
        check("rst_ovf",   32'(ovf),       32'(0));
        check("rst_drop",  32'(drop_cnt),  32'(0));
        @(negedge clk);
        rst = 1'b1;
        model_reset();

`ifndef EDGE_EVENT_PULSE_MODE_EN
        //              a        rdy  clr  valid id  pend     ovf      drop
        tbl[0]  = mk(4'b1111, 1, 0, 0, 0, 4'b1111, 4'b0000, 0); // all edges
        tbl[1]  = mk(4'b1111, 1, 0, 1, 0, 4'b1110, 4'b0000, 0);
        tbl[2]  = mk(4'b1111, 1, 0, 1, 1, 4'b1100, 4'b0000, 0);
        tbl[3]  = mk(4'b1111, 1, 0, 1, 2, 4'b1000, 4'b0000, 0);
        tbl[4]  = mk(4'b1111, 1, 0, 1, 3, 4'b0000, 4'b0000, 0);
        tbl[5]  = mk(4'b1111, 1, 0, 0, 3, 4'b0000, 4'b0000, 0); // id holds
        tbl[6]  = mk(4'b0000, 1, 0, 0, 3, 4'b0000, 4'b0000, 0);
        tbl[7]  = mk(4'b0001, 1, 0, 0, 3, 4'b0001, 4'b0000, 0); // T -> pending
        tbl[8]  = mk(4'b0001, 1, 0, 1, 0, 4'b0000, 4'b0000, 0); // T+2 valid
        tbl[9]  = mk(4'b0001, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[10] = mk(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000, 0); // ch2 edge
        tbl[11] = mk(4'b0000, 0, 0, 1, 2, 4'b0000, 4'b0000, 0); // issued, stalled
        tbl[12] = mk(4'b0100, 0, 0, 1, 2, 4'b0100, 4'b0000, 0); // 2nd edge pends
        tbl[13] = mk(4'b0000, 0, 0, 1, 2, 4'b0100, 4'b0000, 0);
        tbl[14] = mk(4'b0100, 0, 0, 1, 2, 4'b0100, 4'b0100, 1); // 3rd edge drops
        tbl[15] = mk(4'b0000, 0, 1, 1, 2, 4'b0100, 4'b0000, 0); // ovf_clr
        tbl[16] = mk(4'b0000, 1, 0, 1, 2, 4'b0000, 4'b0000, 0);
        tbl[17] = mk(4'b0000, 1, 0, 0, 2, 4'b0000, 4'b0000, 0);
        tbl[18] = mk(4'b1010, 1, 0, 0, 2, 4'b1010, 4'b0000, 0);
        tbl[19] = mk(4'b0000, 0, 0, 1, 3, 4'b0010, 4'b0000, 0); // rr: 3 before 1
        tbl[20] = mk(4'b0000, 0, 0, 1, 3, 4'b0010, 4'b0000, 0);
        tbl[21] = mk(4'b0010, 1, 0, 1, 1, 4'b0010, 4'b0000, 0); // grant+edge ch1
        tbl[22] = mk(4'b0000, 1, 0, 1, 1, 4'b0000, 4'b0000, 0); // ch1 again
        tbl[23] = mk(4'b0000, 1, 0, 0, 1, 4'b0000, 4'b0000, 0);

        for (int v = 0; v < 24; v++) begin
            a = tbl[v].a; out_ready = tbl[v].rdy; ovf_clr = tbl[v].clr; en = 1'b1;
            tick();
            check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(tbl[v].e_valid));
            check($sformatf("vec%0d_id", v),    32'(out_id),    32'(tbl[v].e_id));
            check($sformatf("vec%0d_pend", v),  32'(pending),   32'(tbl[v].e_pend));
            check($sformatf("vec%0d_ovf", v),   32'(ovf),       32'(tbl[v].e_ovf));
            check($sformatf("vec%0d_drop", v),  32'(drop_cnt),  32'(tbl[v].e_drop));
        end
        ovf_clr = 1'b0;

        // Asynchronous reset while an event is presented and others are pending.
        a = 4'b0001; out_ready = 1'b1;
        tick();
        check("ar_pend0", 32'(pending), 32'(4'b0001));
        a = 4'b1011; out_ready = 1'b0;
        tick();
        check("ar_valid", 32'(out_valid), 32'(1));
        check("ar_id",    32'(out_id),    32'(0));
        check("ar_pend",  32'(pending),   32'(4'b1010));
        #2 rst = 1'b0;
        #1;
        check("ar_valid_now", 32'(out_valid), 32'(0));
        check("ar_pend_now",  32'(pending),   32'(0));
        check("ar_id_now",    32'(out_id),    32'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        // a is still 1011: lines high at release count as edges.
        tick();
        check("rel_pend",  32'(pending),   32'(4'b1011));
        check("rel_valid", 32'(out_valid), 32'(0));
        tick();
        check("rel_valid2", 32'(out_valid), 32'(1));
        check("rel_id2",    32'(out_id),    32'(0));
        check("rel_pend2",  32'(pending),   32'(4'b1010));

        // Simultaneous drops and saturation of the drop counter.
        do_reset();
        out_ready = 1'b0;
        a = 4'b1111; tick();
        a = 4'b0000; tick();
        check("sat_id0", 32'(out_id), 32'(0));
        a = 4'b1111; tick();
        check("multi_drop", 32'(drop_cnt), 32'(3));
        check("multi_ovf",  32'(ovf),      32'(4'b1110));
        check("multi_pend", 32'(pending),  32'(4'b1111));
        for (int k = 0; k < 70; k++) begin
            a = 4'b0000; tick();
            a = 4'b1111; tick();
        end
        check("sat_drop", 32'(drop_cnt), 32'(255));
        a = 4'b0000; tick();
        a = 4'b1111; ovf_clr = 1'b1; tick();
        check("clr_drop_wins_cnt", 32'(drop_cnt), 32'(4));
        check("clr_drop_wins_ovf", 32'(ovf),      32'(4'b1111));
        a = 4'b0000; tick();
        check("clr_plain_cnt", 32'(drop_cnt), 32'(0));
        check("clr_plain_ovf", 32'(ovf),      32'(0));
        ovf_clr = 1'b0;

        // The enable blocks only the event; a_r keeps tracking a.
        do_reset();
        en = 1'b0; a = 4'b0001; tick();
        check("en0_pend", 32'(pending), 32'(0));
        en = 1'b1; tick();
        check("en_reenable_pend", 32'(pending), 32'(0));
        tick();
        check("en_reenable_valid", 32'(out_valid), 32'(0));
`else
        // Pulse mode: a[0] = 0,1,0,1,1,0 gives one event only, from the first pulse.
        begin
            logic [N-1:0] seq  [7] = '{4'b0, 4'b1, 4'b0, 4'b1, 4'b1, 4'b0, 4'b0};
            logic         e_v  [7] = '{0, 0, 0, 1, 0, 0, 0};
            logic [N-1:0] e_p  [7] = '{4'b0, 4'b0, 4'b1, 4'b0, 4'b0, 4'b0, 4'b0};
            for (int c = 0; c < 7; c++) begin
                a = seq[c];
                tick();
                check($sformatf("pulse%0d_valid", c), 32'(out_valid), 32'(e_v[c]));
                check($sformatf("pulse%0d_pend", c),  32'(pending),   32'(e_p[c]));
            end
            check("pulse_id", 32'(out_id), 32'(0));
        end
`endif

        // Randomised run against the reference model.
        do_reset();
        use_model = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            a         = a ^ (4'($urandom) & 4'($urandom));
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            tick();
            check("rnd_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) check("rnd_id", 32'(out_id), 32'(m_id));
            check("rnd_pend",  32'(pending),  32'(m_pend));
            check("rnd_ovf",   32'(ovf),      32'(m_ovf));
            check("rnd_drop",  32'(drop_cnt), 32'(m_drop));
        end
        use_model = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N, default 4, meaning number of monitored input lines (2..8).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  detection enable; 0 = new events ignored, pending/arbitration continue.
REQ-005 a  input  N  monitored lines, synchronous to clk.
REQ-006 out_ready  input  1  consumer accepts current event when high with out_valid.
REQ-007 ovf_clr  input  1  one-cycle pulse clearing ovf and drop_cnt.
REQ-008 out_valid  output  1  registered; event present on out_id.
REQ-009 out_id  output  $clog2(N)  registered; index of the channel whose event is presented.
REQ-010 pending  output  N  registered; per-channel recorded-but-not-issued event flags.
REQ-011 ovf  output  N  registered; sticky per-channel overflow flags.
REQ-012 drop_cnt  output  8  registered; saturating count of dropped events, all channels.

Function
REQ-013 Per channel i, a_r[i] SHALL hold a[i] delayed by one clock; event[i] = en & a[i] & ~a_r[i] (rising edge) in default build.
REQ-014 event[i] SHALL set pending[i] at the end of the same cycle; pending[i] visible next cycle.
REQ-015 Arbiter SHALL load a new grant when out_valid==0, or out_valid==1 and out_ready==1 in the same cycle.
REQ-016 Grant selection SHALL be round-robin over pending: search starts at last granted index + 1, wraps N-1 -> 0.
REQ-017 On grant: out_valid<=1, out_id<=selected index, pending[selected]<=0, last-granted pointer<=selected.
REQ-018 If no pending bit set when loading, out_valid<=0; out_id holds its previous value.
REQ-019 While out_valid==1 and out_ready==0, out_valid and out_id SHALL remain stable.
REQ-020 Back-to-back: with out_ready held 1 and multiple pending, one event SHALL issue per cycle.
REQ-021 Latency: edge sampled in cycle T, arbiter idle -> out_valid=1 in cycle T+2.
REQ-022 event[i] in the same cycle pending[i] is cleared by grant: pending[i] SHALL end at 1 (set wins), no overflow.
REQ-023 event[i] while pending[i]==1 and not cleared that cycle: event dropped, ovf[i]<=1, drop_cnt increments.
REQ-024 Multiple simultaneous drops in one cycle SHALL add their count to drop_cnt; drop_cnt saturates at 255.
REQ-025 ovf_clr SHALL clear ovf and drop_cnt; a drop in the same cycle wins (ovf[i]=1, drop_cnt=that cycle's drop count).
REQ-026 en==0 SHALL suppress event generation only; a_r keeps tracking a, so re-enabling while a high gives no event.

Reset
REQ-027 rst low SHALL asynchronously clear a_r, pending, ovf, drop_cnt, out_valid, out_id and set last-granted pointer to N-1 (channel 0 highest priority first).
REQ-028 Reset mid-handshake SHALL discard the presented and all pending events with no partial completion.
REQ-029 A line already high at reset release SHALL count as a rising edge on the first clock (a_r reset to 0).

Configuration
REQ-030 Macro EDGE_EVENT_PULSE_MODE_EN: when defined, event[i] = en & a_r2[i]==0 & a_r[i]==1 & a[i]==0 (isolated one-cycle pulse, pattern 010), a_r2 a second delay stage reset to 0; latency becomes pulse cycle + 3.
REQ-031 Without the macro, rising-edge detection per REQ-013; no a_r2 stage present.

Verification
REQ-032 N=4, a=0000 -> 0001 at cycle T, out_ready=1 -> pending=0001 at T+1, out_valid=1 out_id=0 at T+2, pending=0000.
REQ-033 a 0000 -> 1111 in one cycle, out_ready=1 -> out_id sequence 0,1,2,3 on four consecutive cycles, then out_valid=0.
REQ-034 out_ready=0, ch2 edge issued, two more ch2 edges -> out_id=2 held; pending[2]=1; ovf[2]=1, drop_cnt=1; ovf_clr -> 0.
REQ-035 Grant of ch1 and new ch1 edge in same cycle -> pending[1]=1 after, ovf[1]=0, ch1 issues again later.
REQ-036 Assert rst while out_valid=1 and pending=1010 -> out_valid=0, pending=0000 immediately, before next clk edge.
REQ-037 With EDGE_EVENT_PULSE_MODE_EN, a[0] sequence 0,1,0,1,1,0 -> exactly one event (first pulse); out_valid 3 cycles after the pulse cycle.
